load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Memory-stage load/store unit of the simple MIPS core; sits directly upstream of the word-wide data memory.
//   Accepts one byte/half/word load or store per request and drives the memory's address/write-data/read/write strobes.
//   Sub-word stores use read-modify-write, because the memory is word-only.
//   Loads return data extracted and sign- or zero-extended to 32 bits.
// PARAMETERS
//   ADDR_W     32  request/memory address width
//   MEM_WORDS  32  words in data memory; upper bound for the range check (LSU_MISALIGN_CHECK_EN only)
// PORTS
//   clk          in   1       core clock, posedge active
//   rst_n        in   1       asynchronous active-low reset
//   req_valid    in   1       request present
//   req_ready    out  1       unit can accept (high only in IDLE)
//   req_we       in   1       1=store, 0=load
//   req_size     in   2       00=byte 01=half 10=word 11=reserved
//   req_signed   in   1       loads: 1=sign-extend, 0=zero-extend
//   req_addr     in   ADDR_W  byte address
//   req_wdata    in   32      store data; value in low bits for byte/half
//   resp_valid   out  1       one-cycle completion pulse
//   resp_rdata   out  32      load result; 0 for stores
//   resp_err     out  1       access rejected (valid with resp_valid)
//   mem_addr     out  ADDR_W  byte address to memory; low 2 bits always 00
//   mem_wdata    out  32      word to write
//   mem_read     out  1       memory read strobe
//   mem_write    out  1       memory write strobe; memory writes at the posedge ending the cycle
//   mem_rdata    in   32      memory read data; valid before the posedge ending a mem_read cycle
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
//   Handshake: accept at a posedge when req_valid && req_ready; latch all req_* fields; req_ready=0 until back in IDLE.
//   Byte order is little-endian: lane k = bits 8k+7:8k selected by addr[1:0]; half uses addr[1] (lanes 0-1 or 2-3).
//   FSM states: IDLE, RD, WR, RESP.
//     IDLE -> RD    load, or sub-word store
//     IDLE -> WR    word store
//     IDLE -> RESP  rejected access, with resp_err=1 and no memory strobe
//     RD   -> RESP  load: capture mem_rdata at the posedge ending RD, then extract and extend
//     RD   -> WR    sub-word store: merge the new lanes into the captured word
//     WR   -> RESP
//     RESP -> IDLE  resp_valid=1 for exactly this one cycle
//   mem_read=1 only in RD; mem_write=1 only in WR. They are never high together. mem_addr = {addr[ADDR_W-1:2],2'b00} in RD/WR.
//   Latency from accept to resp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, rejected 1 cycle.
//   Back-to-back requests: a new request is accepted in the cycle after RESP. There is no overlap.
//   Reset mid-RMW: if reset is asserted before the WR posedge, the target word is unmodified.
//   req_signed is ignored for word loads and for all stores.
// CONFIGURATION
//   Macro LSU_MISALIGN_CHECK_EN.
//   Defined: resp_err=1 and no memory access for any of the following:
//     - half access with addr[0]=1
//     - word access with addr[1:0]!=0
//     - size 11
//     - (addr>>2) >= MEM_WORDS
//   Undefined:
//     - low address bits are forced to natural alignment (half clears bit0, word clears bits 1:0)
//     - size 11 is treated as word
//     - no range check; resp_err is tied to 0
// STRUCTURE
//   Package lsu_pkg:
//     - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
//     - FSM state enum lsu_state_t (IDLE, RD, WR, RESP)
//   Sub-module lsu_align, purely combinational:
//     - load lane extract plus sign/zero extend
//     - store lane merge (old word, new data, addr[1:0], size -> merged word)
//   Top level holds the FSM, request registers and captured-word register.
// TESTING
//   1. Hold rst_n=0 -> req_ready=1, resp_valid=0, mem_read=0, mem_write=0. Release -> unit idle, no strobes.
//   2. sw 0xDEADBEEF @0x10, then lw @0x10 -> one mem_write cycle, then resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
//   3. sb 0xAA @0x11 over 0xDEADBEEF -> RD then WR, memory word=0xDEADAAEF. Then lb @0x11 -> 0xFFFFFFAA; lbu -> 0x000000AA.
//   4. lh @0x12 -> 0xFFFFDEAD; lhu @0x12 -> 0x0000DEAD; sh 0x1234 @0x10 -> word=0xDEAD1234, resp_valid 3 cycles after accept.
//   5. lw @0x13 with LSU_MISALIGN_CHECK_EN -> resp_err=1 the next cycle, no mem strobe. Without the macro -> reads word @0x10, resp_err=0.
//   6. sb @0x14, then pulse rst_n low during RD -> mem_write never asserts, word @0x14 unchanged, unit returns to IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, size normalisation.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

    // The reserved encoding behaves as a word access wherever it is not rejected.
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        return (sz == SZ_RSVD) ? SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: little-endian load extract with sign/zero extend, and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = old_word[{addr_lo, 3'b000} +: 8];
        half_lane  = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        load_data  = old_word;
        store_word = new_data;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
                store_word = old_word;
                store_word[{addr_lo, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & half_lane[15]}}, half_lane};
                store_word = addr_lo[1] ? {new_data[15:0], old_word[15:0]}
                                        : {old_word[31:16], new_data[15:0]};
            end
            default: begin
                load_data  = old_word;
                store_word = new_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU driving a word-only data memory; sub-word stores via read-modify-write. Option: LSU_MISALIGN_CHECK_EN.
// Latency accept->resp_valid: load 2, word store 2, sub-word store 3, rejected 1 cycle.
// Backpressure: req_ready is high only in IDLE; one request in flight, no overlap.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    logic              we_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;

    logic [1:0]        size_n;
    logic [ADDR_W-1:0] addr_n;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign size_n    = eff_size(req_size);
    assign mem_wdata = word_q;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        addr_n  = req_addr;
        req_err = (req_size == SZ_RSVD)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
               || ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
    end
`else
    // Without checking, low address bits are dropped to the access's natural alignment.
    always_comb begin
        addr_n  = req_addr;
        req_err = 1'b0;
        if (size_n == SZ_HALF)
            addr_n[0] = 1'b0;
        else if (size_n == SZ_WORD)
            addr_n[1:0] = 2'b00;
    end
`endif

    lsu_align u_align (
        .old_word   (mem_rdata),
        .new_data   (wdata_q),
        .addr_lo    (addr_lo_q),
        .size       (size_q),
        .sign_ext   (sgn_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            word_q     <= 32'h0;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        sgn_q     <= req_signed;
                        size_q    <= size_n;
                        addr_lo_q <= addr_n[1:0];
                        wdata_q   <= req_wdata;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_we && (size_n == SZ_WORD)) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_addr  <= {addr_n[ADDR_W-1:2], 2'b00};
                            word_q    <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= {addr_n[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (we_q) begin
                        // Merge the new lanes into the word just read; written back in WR.
                        state     <= WR;
                        mem_write <= 1'b1;
                        word_q    <= store_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                WR: begin
                    mem_write  <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
